// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - RV32I ALU operand/op sequencer with settle timing and branch evaluation
//
// Captures one ALU request per start pulse, holds the operands and op stable
// for SETTLE_CYCLES, then either drives the result onto the data/address bus
// (arithmetic/logic) or samples the compare flags (branch), and finishes with
// a one-cycle done pulse.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start                      request; accepted only while idle
//   branch, funct3, funct7_b5  operation select, sampled with start
//   imm_sel, to_addr           B-operand source and result destination
//   rs1_data, rs2_data, imm    operand sources, sampled with start
//   alu_eq, alu_lt, alu_ge     ALU compare flags
//   a, b, op                   registered ALU operands and op
//   bus_en, addr_en            ALU result output enables
//   busy, done, taken, err     status and single-cycle result pulses
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        branch,
  input  logic [2:0]  funct3,
  input  logic        funct7_b5,
  input  logic        imm_sel,
  input  logic        to_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic        alu_eq,
  input  logic        alu_lt,
  input  logic        alu_ge,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [3:0]  op,
  output logic        bus_en,
  output logic        addr_en,
  output logic        busy,
  output logic        done,
  output logic        taken,
  output logic        err
);

  localparam logic [3:0] OP_OR  = 4'd0;
  localparam logic [3:0] OP_XOR = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_SL  = 4'd3;
  localparam logic [3:0] OP_SR  = 4'd4;
  localparam logic [3:0] OP_ADD = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  // Branch condition codes held for the flag sample at the end of EXEC.
  localparam logic [1:0] COND_EQ = 2'd0;
  localparam logic [1:0] COND_NE = 2'd1;
  localparam logic [1:0] COND_LT = 2'd2;
  localparam logic [1:0] COND_GE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DRIVE,
    S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        is_branch_q;
  logic        to_addr_q;
  logic        illegal_q;
  logic        taken_q;
  logic [1:0]  cond_q;

  logic [3:0]  dec_op;
  logic        dec_illegal;
  logic        dec_shift;
  logic [1:0]  dec_cond;
  logic [31:0] b_src;
  logic [31:0] b_load;
  logic        cond_met;
  logic        exec_last;
  logic        capture;

  // Request decode, evaluated on the live inputs so it can be captured on
  // the start edge.
  always_comb begin
    dec_op      = OP_ADD;
    dec_illegal = 1'b0;
    dec_shift   = 1'b0;
    dec_cond    = COND_EQ;
    if (branch) begin
      dec_op = OP_SUB;
      case (funct3)
        3'b000:  dec_cond = COND_EQ;
        3'b001:  dec_cond = COND_NE;
        3'b110:  dec_cond = COND_LT;
        3'b111:  dec_cond = COND_GE;
        default: dec_illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        3'b000:  dec_op = (funct7_b5 && !imm_sel) ? OP_SUB : OP_ADD;
        3'b001:  begin dec_op = OP_SL; dec_shift = 1'b1; end
        3'b100:  dec_op = OP_XOR;
        3'b101:  begin dec_op = OP_SR; dec_shift = 1'b1; end
        3'b110:  dec_op = OP_OR;
        3'b111:  dec_op = OP_AND;
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  // Shift amounts only use the low five bits; the rest are cleared so the
  // ALU never sees a stray high-order shift amount.
  assign b_src  = imm_sel ? imm : rs2_data;
  assign b_load = dec_shift ? {27'd0, b_src[4:0]} : b_src;

  always_comb begin
    cond_met = 1'b0;
    case (cond_q)
      COND_EQ: cond_met = alu_eq;
      COND_NE: cond_met = !alu_eq;
      COND_LT: cond_met = alu_lt;
      COND_GE: cond_met = alu_ge;
      default: cond_met = 1'b0;
    endcase
  end

  assign capture   = (state_q == S_IDLE) && start;
  // <= 1 rather than == 1 keeps a zero-loaded counter from wrapping.
  assign exec_last = (cnt_q <= 4'd1);

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    err     = 1'b0;
    taken   = 1'b0;
    bus_en  = 1'b0;
    addr_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = dec_illegal ? S_FIN : S_EXEC;
      end
      S_EXEC: begin
        if (exec_last) state_d = is_branch_q ? S_FIN : S_DRIVE;
      end
      S_DRIVE: begin
        addr_en = to_addr_q;
        bus_en  = !to_addr_q;
        state_d = S_FIN;
      end
      S_FIN: begin
        done    = 1'b1;
        err     = illegal_q;
        taken   = taken_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a           <= 32'd0;
      b           <= 32'd0;
      op          <= OP_OR;
      cnt_q       <= 4'd0;
      is_branch_q <= 1'b0;
      to_addr_q   <= 1'b0;
      illegal_q   <= 1'b0;
      taken_q     <= 1'b0;
      cond_q      <= COND_EQ;
    end else begin
      state_q <= state_d;
      if (capture) begin
        a           <= rs1_data;
        b           <= b_load;
        op          <= dec_op;
        cnt_q       <= SETTLE_INIT;
        is_branch_q <= branch;
        to_addr_q   <= to_addr;
        illegal_q   <= dec_illegal;
        cond_q      <= dec_cond;
        taken_q     <= 1'b0;
      end else if (state_q == S_EXEC) begin
        if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        if (exec_last && is_branch_q) taken_q <= cond_met;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer
module tb_alu_sequencer;

  localparam int S = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        branch;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic        imm_sel;
  logic        to_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        alu_eq;
  logic        alu_lt;
  logic        alu_ge;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic        bus_en;
  logic        addr_en;
  logic        busy;
  logic        done;
  logic        taken;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  logic got_taken;
  logic got_err;

  alu_sequencer #(.SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .branch    (branch),
    .funct3    (funct3),
    .funct7_b5 (funct7_b5),
    .imm_sel   (imm_sel),
    .to_addr   (to_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .imm       (imm),
    .alu_eq    (alu_eq),
    .alu_lt    (alu_lt),
    .alu_ge    (alu_ge),
    .a         (a),
    .b         (b),
    .op        (op),
    .bus_en    (bus_en),
    .addr_en   (addr_en),
    .busy      (busy),
    .done      (done),
    .taken     (taken),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Issues one request starting just after a falling edge and follows it to
  // idle, comparing every cycle with the timeline predicted from the
  // operation rules. Returns at a falling edge with the block idle.
  task automatic do_op(input logic br, input logic [2:0] f3, input logic f7,
                       input logic isel, input logic taddr,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                       input logic eq, input logic lt, input logic ge);
    logic [31:0] exp_b;
    logic [3:0]  exp_op;
    logic        ill;
    logic        cond;
    logic        drv;
    int          total;

    exp_b  = isel ? im : r2;
    exp_op = 4'd0;
    ill    = 1'b0;
    cond   = 1'b0;
    if (br) begin
      exp_op = 4'd6;
      case (f3)
        3'd0:    cond = eq;
        3'd1:    cond = !eq;
        3'd6:    cond = lt;
        3'd7:    cond = ge;
        default: ill = 1'b1;
      endcase
    end else begin
      case (f3)
        3'd0:    exp_op = (f7 && !isel) ? 4'd6 : 4'd5;
        3'd1:    exp_op = 4'd3;
        3'd4:    exp_op = 4'd1;
        3'd5:    exp_op = 4'd4;
        3'd6:    exp_op = 4'd0;
        3'd7:    exp_op = 4'd2;
        default: ill = 1'b1;
      endcase
      if (f3 == 3'd1 || f3 == 3'd5) exp_b = exp_b & 32'h1F;
    end
    total = ill ? 1 : (br ? S + 1 : S + 2);

    branch    = br;
    funct3    = f3;
    funct7_b5 = f7;
    imm_sel   = isel;
    to_addr   = taddr;
    rs1_data  = r1;
    rs2_data  = r2;
    imm       = im;
    alu_eq    = eq;
    alu_lt    = lt;
    alu_ge    = ge;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Request inputs are only meaningful on the capture edge.
    rs1_data = $urandom;
    rs2_data = $urandom;
    imm      = $urandom;
    funct3   = 3'($urandom);
    branch   = 1'($urandom);

    got_taken = 1'b0;
    got_err   = 1'b0;
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      drv = !br && !ill && (k == S + 1);
      chk1($sformatf("busy@%0d", k), busy, k <= total);
      chk1($sformatf("done@%0d", k), done, k == total);
      chk1($sformatf("err@%0d", k), err, ill && (k == total));
      chk1($sformatf("taken@%0d", k), taken, br && !ill && cond && (k == total));
      chk1($sformatf("bus_en@%0d", k), bus_en, drv && !taddr);
      chk1($sformatf("addr_en@%0d", k), addr_en, drv && taddr);
      chk32($sformatf("a@%0d", k), a, r1);
      chk32($sformatf("b@%0d", k), b, exp_b);
      if (!ill) chk32($sformatf("op@%0d", k), {28'd0, op}, {28'd0, exp_op});
      if (k == total) begin
        got_taken = taken;
        got_err   = err;
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    branch    = 1'b0;
    funct3    = 3'd0;
    funct7_b5 = 1'b0;
    imm_sel   = 1'b0;
    to_addr   = 1'b0;
    rs1_data  = 32'd0;
    rs2_data  = 32'd0;
    imm       = 32'd0;
    alu_eq    = 1'b0;
    alu_lt    = 1'b0;
    alu_ge    = 1'b0;

    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_taken", taken, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_bus_en", bus_en, 1'b0);
    chk1("rst_addr_en", addr_en, 1'b0);
    chk32("rst_a", a, 32'd0);
    chk32("rst_b", b, 32'd0);
    chk32("rst_op", {28'd0, op}, 32'd0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD accepted on the first edge after release.
    do_op(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0);
    chk32("add_op", {28'd0, op}, 32'd5);
    chk32("add_a", a, 32'd5);
    chk32("add_b", b, 32'd7);

    // SUB to the address bus.
    do_op(1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 32'd100, 32'd30, 32'd0, 1'b0, 1'b0, 1'b0);
    chk32("sub_op", {28'd0, op}, 32'd6);

    // Shift with immediate: high bits of b cleared.
    do_op(1'b0, 3'b001, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF, 32'hFFFF_FFE3,
          1'b0, 1'b0, 1'b0);
    chk32("sl_b", b, 32'h0000_0003);
    chk32("sl_op", {28'd0, op}, 32'd3);

    // BNE, not equal then equal.
    do_op(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 32'd9, 32'd3, 32'd0, 1'b0, 1'b1, 1'b0);
    chk1("bne_taken", got_taken, 1'b1);
    do_op(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 1'b1);
    chk1("bne_not_taken", got_taken, 1'b0);

    // Illegal arithmetic funct3.
    do_op(1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0);
    chk1("illegal_err", got_err, 1'b1);

    // start held high: ignored while busy, re-accepted on the single idle cycle.
    branch    = 1'b0;
    funct3    = 3'b000;
    funct7_b5 = 1'b0;
    imm_sel   = 1'b0;
    to_addr   = 1'b0;
    rs1_data  = 32'h11;
    rs2_data  = 32'h2;
    start     = 1'b1;
    @(posedge clk);
    #1;
    rs1_data = 32'h22;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk1($sformatf("held_busy@%0d", k), busy, 1'b1);
      chk32($sformatf("held_a@%0d", k), a, 32'h11);
    end
    @(negedge clk);
    chk1("held_idle", busy, 1'b0);
    chk32("held_idle_a", a, 32'h11);
    @(negedge clk);
    chk1("held_restart", busy, 1'b1);
    chk32("held_new_a", a, 32'h22);
    start = 1'b0;
    for (int k = 0; k < 3; k++) @(negedge clk);
    chk1("held_back_idle", busy, 1'b0);

    // Reset while driving the data bus.
    rs1_data = 32'hA5A5_0001;
    rs2_data = 32'd4;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk1("pre_rst_bus_en", bus_en, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_bus_en", bus_en, 1'b0);
    chk32("mid_rst_a", a, 32'd0);
    chk1("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    chk1("mid_rst_done", done, 1'b0);
    rst_n = 1'b1;
    do_op(1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0,
          1'b0, 1'b0, 1'b0);

    // Randomised requests.
    for (int i = 0; i < 40; i++) begin
      do_op(1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
